// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: FSM states,
// datapath select codes, trap causes and the one-hot instruction class layout.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_t;

    // PC source
    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    // ALU operand sources
    localparam logic ALU_A_RS1 = 1'b0;
    localparam logic ALU_A_PC  = 1'b1;
    localparam logic ALU_B_RS2 = 1'b0;
    localparam logic ALU_B_IMM = 1'b1;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // Writeback sources
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_UIMM = 2'b11;

    // Trap causes
    localparam logic [1:0] TRAP_NONE        = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL     = 2'b01;
    localparam logic [1:0] TRAP_MEM_TIMEOUT = 2'b10;

    // One-hot class register bit positions
    localparam int CLS_W      = 9;
    localparam int CLS_LOAD   = 0;
    localparam int CLS_STORE  = 1;
    localparam int CLS_BRANCH = 2;
    localparam int CLS_JALR   = 3;
    localparam int CLS_JAL    = 4;
    localparam int CLS_LUI    = 5;
    localparam int CLS_AUIPC  = 6;
    localparam int CLS_OP_IMM = 7;
    localparam int CLS_OP     = 8;

    typedef logic [CLS_W-1:0] cls_t;

    // True when exactly one class flag is set.
    function automatic logic is_one_hot(input cls_t c);
        return (c != '0) && ((c & (c - cls_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory-wait cycles and flags when the count reaches
// MEM_TIMEOUT. The controller decides what an expiry means.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TMR_W       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [TMR_W-1:0] count;

    // Clear has priority; increment only while a request is waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + TMR_W'(1);
        end
    end

    assign expired = (count == TMR_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: fetch, decode, execute,
// memory and writeback sequencing, memory handshake, wait timeout and
// retired-instruction counting. One instruction in flight at a time.
//
// Memory handshake: mem_req is a request that holds, together with mem_we
// and mem_sel_data, until the cycle mem_ready is seen high; that cycle
// completes the access. mem_ready while mem_req is low is ignored.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TMR_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        store,
    input  logic        branch,
    input  logic        jalr,
    input  logic        jal,
    input  logic        lui,
    input  logic        auipc,
    input  logic        op_imm,
    input  logic        op,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel_data,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [2:0]  imm_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    state_t state_q;
    cls_t   cls_q;
    cls_t   flags;
    logic   waiting;
    logic   tmr_inc;
    logic   expired;

    assign flags = {op, op_imm, auipc, lui, jal, jalr, branch, store, load};
    assign state = state_q;

    // The counter runs only on memory cycles without mem_ready; every other
    // cycle (including completion and any non-memory state) clears it.
    assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign tmr_inc = waiting && !mem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TMR_W      (TMR_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (!tmr_inc),
        .inc    (tmr_inc),
        .expired(expired)
    );

    // State sequencing, class capture, sticky trap cause and instret.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            cls_q      <= '0;
            trap_cause <= TRAP_NONE;
            instret    <= '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (mem_ready) begin
                        state_q <= ST_DECODE;
                    end else if (expired) begin
                        state_q    <= ST_TRAP;
                        trap_cause <= TRAP_MEM_TIMEOUT;
                    end
                end
                ST_DECODE: begin
                    cls_q <= flags;
                    if (is_one_hot(flags)) begin
                        state_q <= ST_EXEC;
                    end else begin
                        state_q    <= ST_TRAP;
                        trap_cause <= TRAP_ILLEGAL;
                    end
                end
                ST_EXEC: begin
                    if (cls_q[CLS_BRANCH]) begin
                        state_q <= ST_FETCH;
                        instret <= instret + 32'd1;
                    end else if (cls_q[CLS_LOAD] || cls_q[CLS_STORE]) begin
                        state_q <= ST_MEM;
                    end else begin
                        state_q <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        if (cls_q[CLS_STORE]) begin
                            state_q <= ST_FETCH;
                            instret <= instret + 32'd1;
                        end else begin
                            state_q <= ST_WB;
                        end
                    end else if (expired) begin
                        state_q    <= ST_TRAP;
                        trap_cause <= TRAP_MEM_TIMEOUT;
                    end
                end
                ST_WB: begin
                    state_q <= ST_FETCH;
                    instret <= instret + 32'd1;
                end
                ST_TRAP: begin
                    state_q <= ST_TRAP;
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    // Strobes and selects decode from state and class; rst forces every
    // strobe low at once so an in-progress access is dropped immediately.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_sel_data = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_PLUS4;
        alu_a_sel    = ALU_A_RS1;
        alu_b_sel    = ALU_B_RS2;
        imm_sel      = IMM_I;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU;

        if (!rst) begin
            // Operand selects chosen in EXEC stay put through MEM and WB.
            if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
                if (cls_q[CLS_LOAD] || cls_q[CLS_OP_IMM] || cls_q[CLS_JALR]) begin
                    imm_sel   = IMM_I;
                    alu_b_sel = ALU_B_IMM;
                end else if (cls_q[CLS_STORE]) begin
                    imm_sel   = IMM_S;
                    alu_b_sel = ALU_B_IMM;
                end else if (cls_q[CLS_AUIPC]) begin
                    alu_a_sel = ALU_A_PC;
                    imm_sel   = IMM_U;
                    alu_b_sel = ALU_B_IMM;
                end
            end

            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                end
                ST_EXEC: begin
                    if (cls_q[CLS_BRANCH]) begin
                        imm_sel = IMM_B;
                        pc_we   = 1'b1;
                        pc_sel  = br_taken ? PC_IMM : PC_PLUS4;
                    end
                end
                ST_MEM: begin
                    mem_req      = 1'b1;
                    mem_sel_data = 1'b1;
                    mem_we       = cls_q[CLS_STORE];
                    if (cls_q[CLS_STORE] && mem_ready) begin
                        pc_we  = 1'b1;
                        pc_sel = PC_PLUS4;
                    end
                end
                ST_WB: begin
                    rf_we = 1'b1;
                    pc_we = 1'b1;
                    if (cls_q[CLS_LOAD]) begin
                        wb_sel = WB_LOAD;
                    end else if (cls_q[CLS_JAL] || cls_q[CLS_JALR]) begin
                        wb_sel = WB_PC4;
                    end else if (cls_q[CLS_LUI]) begin
                        wb_sel = WB_UIMM;
                    end
                    if (cls_q[CLS_JAL]) begin
                        pc_sel  = PC_IMM;
                        imm_sel = IMM_J;
                    end else if (cls_q[CLS_JALR]) begin
                        pc_sel = PC_ALU;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected output snapshots are
// queued when an instruction is scheduled and checked as the DUT steps.
module tb_multicycle_ctrl;

    localparam int TO = 4;

    localparam int K_LOAD   = 0;
    localparam int K_STORE  = 1;
    localparam int K_BRANCH = 2;
    localparam int K_JALR   = 3;
    localparam int K_JAL    = 4;
    localparam int K_LUI    = 5;
    localparam int K_AUIPC  = 6;
    localparam int K_OP_IMM = 7;
    localparam int K_OP     = 8;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       dsel;
        logic       irwe;
        logic       pcwe;
        logic [1:0] pcs;
        logic       asel;
        logic       bsel;
        logic [2:0] imm;
        logic       rfwe;
        logic [1:0] wbs;
        logic [1:0] tc;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  fl = '0;
    logic        br_taken = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, mem_sel_data, ir_we, pc_we;
    logic [1:0]  pc_sel;
    logic        alu_a_sel, alu_b_sel;
    logic [2:0]  imm_sel;
    logic        rf_we;
    logic [1:0]  wb_sel, trap_cause;
    logic [2:0]  state;
    logic [31:0] instret;
    obs_t        cur;

    logic [19:0] exp_q[$];
    logic        rdy_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_instret = '0;
    string       test_name = "reset";

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .TMR_W(16)) dut (
        .clk(clk), .rst(rst),
        .load(fl[K_LOAD]), .store(fl[K_STORE]), .branch(fl[K_BRANCH]),
        .jalr(fl[K_JALR]), .jal(fl[K_JAL]), .lui(fl[K_LUI]),
        .auipc(fl[K_AUIPC]), .op_imm(fl[K_OP_IMM]), .op(fl[K_OP]),
        .br_taken(br_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel_data(mem_sel_data),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .imm_sel(imm_sel),
        .rf_we(rf_we), .wb_sel(wb_sel), .trap_cause(trap_cause),
        .state(state), .instret(instret)
    );

    assign cur = {state, mem_req, mem_we, mem_sel_data, ir_we, pc_we, pc_sel,
                  alu_a_sel, alu_b_sel, imm_sel, rf_we, wb_sel, trap_cause};

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s/%s observed=%h expected=%h", test_name, tag, got, want);
        end
    endtask

    function automatic obs_t blank(input logic [2:0] st);
        obs_t o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    // Operand selects that EXEC sets up and MEM/WB keep.
    function automatic obs_t held(input obs_t o, input int k);
        obs_t r;
        r = o;
        if (k == K_LOAD || k == K_OP_IMM || k == K_JALR) begin
            r.imm = 3'd0; r.bsel = 1'b1;
        end else if (k == K_STORE) begin
            r.imm = 3'd1; r.bsel = 1'b1;
        end else if (k == K_AUIPC) begin
            r.asel = 1'b1; r.imm = 3'd3; r.bsel = 1'b1;
        end
        return r;
    endfunction

    task automatic push(input logic rdy, input obs_t e);
        exp_q.push_back(e);
        rdy_q.push_back(rdy);
    endtask

    task automatic push_fetch(input int fwait);
        obs_t e;
        for (int i = 0; i < fwait; i++) begin
            e = blank(3'd0); e.req = 1'b1;
            push(1'b0, e);
        end
        e = blank(3'd0); e.req = 1'b1; e.irwe = 1'b1;
        push(1'b1, e);
    endtask

    // Expected per-cycle snapshots for one legal instruction of class k.
    task automatic queue_instr(input int k, input logic taken, input int fwait, input int dwait);
        obs_t e;
        push_fetch(fwait);
        push(1'($urandom_range(0, 1)), blank(3'd1));
        e = held(blank(3'd2), k);
        if (k == K_BRANCH) begin
            e.imm = 3'd2; e.pcwe = 1'b1; e.pcs = taken ? 2'b01 : 2'b00;
        end
        push(1'($urandom_range(0, 1)), e);
        if (k == K_LOAD || k == K_STORE) begin
            e = held(blank(3'd3), k);
            e.req = 1'b1; e.dsel = 1'b1; e.we = (k == K_STORE);
            for (int i = 0; i < dwait; i++) push(1'b0, e);
            if (k == K_STORE) begin
                e.pcwe = 1'b1; e.pcs = 2'b00;
            end
            push(1'b1, e);
        end
        if (k != K_BRANCH && k != K_STORE) begin
            e = held(blank(3'd4), k);
            e.rfwe = 1'b1; e.pcwe = 1'b1;
            case (k)
                K_LOAD:  e.wbs = 2'b01;
                K_JAL:   begin e.wbs = 2'b10; e.pcs = 2'b01; e.imm = 3'd4; end
                K_JALR:  begin e.wbs = 2'b10; e.pcs = 2'b10; end
                K_LUI:   e.wbs = 2'b11;
                default: e.wbs = 2'b00;
            endcase
            push(1'($urandom_range(0, 1)), e);
        end
    endtask

    // Pop one snapshot per cycle, drive its mem_ready, compare mid-cycle.
    task automatic drain(input string tag);
        logic [19:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mem_ready = rdy_q.pop_front();
            @(negedge clk);
            check(tag, 32'(cur), 32'(e));
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
    endtask

    task automatic run_instr(input string name, input int k, input logic taken,
                             input int fwait, input int dwait);
        test_name = name;
        fl = 9'(1) << k;
        br_taken = taken;
        queue_instr(k, taken, fwait, dwait);
        drain("obs");
        exp_instret++;
        check("instret", instret, exp_instret);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_obs", 32'(cur), 32'(blank(3'd0)));
        @(posedge clk);
        #1 rst = 1'b0;
        exp_instret = '0;
        check("rst_instret", instret, 32'd0);
    endtask

    task automatic trap_tail(input logic [1:0] tc);
        obs_t e;
        e = blank(3'd7); e.tc = tc;
        for (int i = 0; i < 3; i++) push(1'($urandom_range(0, 1)), e);
    endtask

    // Directed sequence
    initial begin
        obs_t e;
        #1;
        check("rst_obs", 32'(cur), 32'(blank(3'd0)));
        check("rst_instret", instret, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        run_instr("addi", K_OP_IMM, 1'b0, 0, 0);
        run_instr("lw_wait3", K_LOAD, 1'b0, 0, 3);
        run_instr("beq_taken", K_BRANCH, 1'b1, 0, 0);
        run_instr("beq_not_taken", K_BRANCH, 1'b0, 0, 0);
        run_instr("jalr", K_JALR, 1'b0, 0, 0);
        run_instr("sw", K_STORE, 1'b0, 0, 0);
        run_instr("op", K_OP, 1'b0, $urandom_range(0, 3), 0);
        run_instr("lui", K_LUI, 1'b0, $urandom_range(0, 3), 0);
        run_instr("auipc", K_AUIPC, 1'b0, 0, 0);
        run_instr("jal", K_JAL, 1'b0, 1, 0);
        run_instr("sw_wait", K_STORE, 1'b0, 2, $urandom_range(1, 3));
        // Ready arriving exactly on the timeout cycle still completes.
        run_instr("fetch_at_timeout", K_OP, 1'b0, TO, 0);
        run_instr("load_at_timeout", K_LOAD, 1'b0, 0, TO);

        // Illegal: no class flag.
        test_name = "illegal_none";
        fl = '0;
        push_fetch(0);
        push(1'b0, blank(3'd1));
        trap_tail(2'b01);
        drain("obs");
        check("instret", instret, exp_instret);

        // Illegal: two class flags.
        do_reset();
        test_name = "illegal_two";
        fl = '0; fl[K_LOAD] = 1'b1; fl[K_STORE] = 1'b1;
        push_fetch(0);
        push(1'b0, blank(3'd1));
        trap_tail(2'b01);
        drain("obs");
        check("instret", instret, 32'd0);

        // Fetch never answered: TO+1 FETCH cycles, then timeout trap.
        do_reset();
        test_name = "fetch_timeout";
        fl = 9'(1) << K_OP;
        for (int i = 0; i <= TO; i++) begin
            e = blank(3'd0); e.req = 1'b1;
            push(1'b0, e);
        end
        trap_tail(2'b10);
        drain("obs");
        check("instret", instret, 32'd0);

        // Store never answered in MEM.
        do_reset();
        test_name = "mem_timeout";
        fl = 9'(1) << K_STORE;
        push_fetch(0);
        push(1'b0, blank(3'd1));
        push(1'b0, held(blank(3'd2), K_STORE));
        e = held(blank(3'd3), K_STORE);
        e.req = 1'b1; e.dsel = 1'b1; e.we = 1'b1;
        for (int i = 0; i <= TO; i++) push(1'b0, e);
        trap_tail(2'b10);
        drain("obs");
        check("instret", instret, 32'd0);

        // Reset pulsed in the middle of a MEM access.
        do_reset();
        run_instr("pre_abort", K_OP_IMM, 1'b0, 0, 0);
        test_name = "rst_mid_mem";
        fl = 9'(1) << K_LOAD;
        push_fetch(0);
        push(1'b0, blank(3'd1));
        push(1'b0, held(blank(3'd2), K_LOAD));
        drain("obs");
        #2;
        check("mem_req_before", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        check("mem_req_async", 32'(mem_req), 32'd0);
        check("state_async", 32'(state), 32'd0);
        check("instret_async", instret, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_instret = '0;
        run_instr("after_abort", K_OP_IMM, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
